tpu_rf_mc: RTL

Multi-channel register file for the timer-processing unit, replacing the single-channel TPU register bank. It exposes NCH identical channel windows on the 8-bit host register bus, with a one-cycle ready handshake on every access. Each channel has sticky write-1-to-clear interrupt flags and an atomic 16-bit timer-interval update, and the block drives one combined interrupt line. It sits between the host bus decoder and the NCH TPU slot engines.

---
 rtl/tpu_rf_mc.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/tpu_rf_mc.sv
// Multi-channel TPU register file: NCH channel windows on the 8-bit host bus with a
// one-cycle ready handshake. Define TPU_RF_INTCNT_EN to build the per-channel INT_CNT counters.
module tpu_rf_mc #(
  parameter int unsigned NCH       = 4,
  parameter logic [7:0]  BASE_ADDR = 8'h20,
  parameter int unsigned CH_STRIDE = 8
) (
  input  logic                SYS_CLK,
  input  logic                RST,
  input  logic                we_rf,
  input  logic                re_rf,
  input  logic [7:0]          addr_rf,
  input  logic [7:0]          data_rf,
  input  logic [NCH-1:0]      TPUINT_RF,
  output logic                ready_rf,
  output logic [7:0]          data_out,
  output logic [NCH-1:0]      RSTTPU,
  output logic [NCH-1:0]      TXSLOT_EN,
  output logic [NCH-1:0]      RXSLOT_EN,
  output logic [NCH-1:0]      TIMERINTMSK,
  output logic [NCH-1:0]      INTFLAG,
  output logic [NCH*8-1:0]    TX_SLOT,
  output logic [NCH*8-1:0]    RX_SLOT,
  output logic [NCH*16-1:0]   TIMER_INT_VALUE,
  output logic                IRQ
);

  localparam int BaseI   = int'(BASE_ADDR);
  localparam int StrideI = int'(CH_STRIDE);
  localparam int SumI    = BaseI + int'(NCH) * StrideI;

  localparam logic [2:0] OffCtrl  = 3'd0;
  localparam logic [2:0] OffTx    = 3'd1;
  localparam logic [2:0] OffRx    = 3'd2;
  localparam logic [2:0] OffTimHi = 3'd3;
  localparam logic [2:0] OffTimLo = 3'd4;
  localparam logic [2:0] OffCnt   = 3'd5;

  logic [NCH-1:0]         tx_en_q, tx_en_d;
  logic [NCH-1:0]         rx_en_q, rx_en_d;
  logic [NCH-1:0]         msk_q, msk_d;
  logic [NCH-1:0]         flag_q, flag_d;
  logic [NCH-1:0][2:0]    spare_q, spare_d;
  logic [NCH-1:0][7:0]    tx_slot_q, tx_slot_d;
  logic [NCH-1:0][7:0]    rx_slot_q, rx_slot_d;
  logic [NCH-1:0][7:0]    shadow_q, shadow_d;
  logic [NCH-1:0][15:0]   timer_q, timer_d;
  logic [NCH-1:0]         prev_q;
  logic [NCH-1:0]         rsttpu_q, rsttpu_d;
  logic                   ready_q;
  logic [7:0]             dout_q, dout_d;
  logic                   irq_q, irq_d;
`ifdef TPU_RF_INTCNT_EN
  logic [NCH-1:0][7:0]    cnt_q, cnt_d;
`endif

  int                     addr_int;
  logic [NCH-1:0]         sel_ch;
  logic [2:0]             sel_off;
  logic                   hit_sum;
  logic [NCH-1:0]         evt;
  logic [7:0]             rdata;

  assign addr_int = {24'd0, addr_rf};
  assign evt      = TPUINT_RF & ~prev_q;

  // Address decode: one-hot channel select plus the offset inside the window.
  always_comb begin
    sel_ch  = '0;
    sel_off = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      if (addr_int >= BaseI + c * StrideI && addr_int < BaseI + c * StrideI + 6) begin
        sel_ch[c] = 1'b1;
        sel_off   = 3'(addr_int - BaseI - c * StrideI);
      end
    end
    hit_sum = (addr_int == SumI);
  end

  // Read mux always reflects pre-write state, so a simultaneous write returns the old value.
  always_comb begin
    rdata = 8'h00;
    if (hit_sum) begin
      rdata = 8'(flag_q);
    end else begin
      for (int c = 0; c < int'(NCH); c++) begin
        if (sel_ch[c]) begin
          case (sel_off)
            OffCtrl:  rdata = {spare_q[c], flag_q[c], msk_q[c], rx_en_q[c], tx_en_q[c], 1'b0};
            OffTx:    rdata = tx_slot_q[c];
            OffRx:    rdata = rx_slot_q[c];
            OffTimHi: rdata = timer_q[c][15:8];
            OffTimLo: rdata = timer_q[c][7:0];
`ifdef TPU_RF_INTCNT_EN
            OffCnt:   rdata = cnt_q[c];
`endif
            default:  rdata = 8'h00;
          endcase
        end
      end
    end
  end

  always_comb begin
    tx_en_d   = tx_en_q;
    rx_en_d   = rx_en_q;
    msk_d     = msk_q;
    flag_d    = flag_q;
    spare_d   = spare_q;
    tx_slot_d = tx_slot_q;
    rx_slot_d = rx_slot_q;
    shadow_d  = shadow_q;
    timer_d   = timer_q;
    rsttpu_d  = '0;
`ifdef TPU_RF_INTCNT_EN
    cnt_d     = cnt_q;
`endif
    for (int c = 0; c < int'(NCH); c++) begin
      if (we_rf && sel_ch[c]) begin
        case (sel_off)
          OffCtrl: begin
            rsttpu_d[c] = data_rf[0];
            tx_en_d[c]  = data_rf[1];
            rx_en_d[c]  = data_rf[2];
            msk_d[c]    = data_rf[3];
            spare_d[c]  = data_rf[7:5];
            if (data_rf[4]) flag_d[c] = 1'b0;
          end
          OffTx:    tx_slot_d[c] = data_rf;
          OffRx:    rx_slot_d[c] = data_rf;
          OffTimHi: shadow_d[c]  = data_rf;
          OffTimLo: timer_d[c]   = {shadow_q[c], data_rf};
`ifdef TPU_RF_INTCNT_EN
          OffCnt:   cnt_d[c]     = 8'h00;
`endif
          default: ;
        endcase
      end
      // A new event overrides a same-edge clear.
      if (evt[c]) begin
        flag_d[c] = 1'b1;
`ifdef TPU_RF_INTCNT_EN
        if (cnt_d[c] != 8'hFF) cnt_d[c] = cnt_d[c] + 8'd1;
`endif
      end
    end
  end

  always_comb begin
    dout_d = re_rf ? rdata : 8'h00;
    irq_d  = |(flag_q & ~msk_q);
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      tx_en_q   <= '0;
      rx_en_q   <= '0;
      msk_q     <= '0;
      flag_q    <= '0;
      spare_q   <= '0;
      tx_slot_q <= '0;
      rx_slot_q <= '0;
      shadow_q  <= '0;
      timer_q   <= '0;
      prev_q    <= '0;
      rsttpu_q  <= '0;
      ready_q   <= 1'b0;
      dout_q    <= 8'h00;
      irq_q     <= 1'b0;
`ifdef TPU_RF_INTCNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      tx_en_q   <= tx_en_d;
      rx_en_q   <= rx_en_d;
      msk_q     <= msk_d;
      flag_q    <= flag_d;
      spare_q   <= spare_d;
      tx_slot_q <= tx_slot_d;
      rx_slot_q <= rx_slot_d;
      shadow_q  <= shadow_d;
      timer_q   <= timer_d;
      prev_q    <= TPUINT_RF;
      rsttpu_q  <= rsttpu_d;
      ready_q   <= we_rf | re_rf;
      dout_q    <= dout_d;
      irq_q     <= irq_d;
`ifdef TPU_RF_INTCNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign ready_rf        = ready_q;
  assign data_out        = dout_q;
  assign RSTTPU          = rsttpu_q;
  assign TXSLOT_EN       = tx_en_q;
  assign RXSLOT_EN       = rx_en_q;
  assign TIMERINTMSK     = msk_q;
  assign INTFLAG         = flag_q;
  assign TX_SLOT         = tx_slot_q;
  assign RX_SLOT         = rx_slot_q;
  assign TIMER_INT_VALUE = timer_q;
  assign IRQ             = irq_q;

endmodule
